// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with enable/freeze, load strobe and
// a self-running scan mode that walks the asserted line across all outputs.
// Optional build macro: DECODER_ACTIVE_LOW_EN (y emitted one-cold).
module decoder_nto2n_seq #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned SCAN_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [(2**SEL_W)-1:0]   y,
  output logic                    y_valid,
  output logic [SEL_W-1:0]        scan_idx,
  output logic                    wrap
);

  localparam int unsigned OUT_W = 2**SEL_W;
  localparam logic [15:0] HoldLast = 16'(SCAN_HOLD - 1);
  localparam logic [SEL_W-1:0] IdxLast = '1;

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d, idx_inc;
  logic [15:0]        hold_q, hold_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   y_q, y_d;

  // State register; reset aborts any scan immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only an enabled load changes the mode of operation.
  always_comb begin
    state_d = state_q;
    if (en && load) begin
      state_d = mode ? StScan : StDirect;
    end
  end

  // Datapath next state: load has priority over a scheduled scan step.
  always_comb begin
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    y_d     = y_q;
    wrap_d  = 1'b0;
    idx_inc = idx_q + SEL_W'(1);
    if (en) begin
      if (load) begin
        idx_d      = sel;
        hold_d     = '0;
        valid_d    = 1'b1;
        y_d        = '0;
        y_d[sel]   = 1'b1;
      end else if (state_q == StScan) begin
        if (hold_q == HoldLast) begin
          hold_d       = '0;
          idx_d        = idx_inc;
          y_d          = '0;
          y_d[idx_inc] = 1'b1;
          wrap_d       = (idx_q == IdxLast);
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
    end
  end

  // Datapath registers; with en=0 the next-state logic holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  // Outputs: optional one-cold polarity, wrap suppressed while frozen.
  always_comb begin
`ifdef DECODER_ACTIVE_LOW_EN
    y = ~y_q;
`else
    y = y_q;
`endif
    y_valid  = valid_q;
    scan_idx = idx_q;
    wrap     = wrap_q & en;
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq: three instances cover the default
// configuration, SCAN_HOLD=1, and SEL_W=4.
module tb_decoder_nto2n_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Instance a: SEL_W=3, SCAN_HOLD=4
  logic       en_a, load_a, mode_a;
  logic [2:0] sel_a;
  logic [7:0] y_a;
  logic       v_a, w_a;
  logic [2:0] idx_a;

  // Instance b: SEL_W=3, SCAN_HOLD=1
  logic       en_b, load_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] y_b;
  logic       v_b, w_b;
  logic [2:0] idx_b;

  // Instance c: SEL_W=4, SCAN_HOLD=4
  logic        en_c, load_c, mode_c;
  logic [3:0]  sel_c;
  logic [15:0] y_c;
  logic        v_c, w_c;
  logic [3:0]  idx_c;

  decoder_nto2n_seq #(.SEL_W(3), .SCAN_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .mode(mode_a), .sel(sel_a),
    .y(y_a), .y_valid(v_a), .scan_idx(idx_a), .wrap(w_a)
  );

  decoder_nto2n_seq #(.SEL_W(3), .SCAN_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b), .mode(mode_b), .sel(sel_b),
    .y(y_b), .y_valid(v_b), .scan_idx(idx_b), .wrap(w_b)
  );

  decoder_nto2n_seq #(.SEL_W(4), .SCAN_HOLD(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .load(load_c), .mode(mode_c), .sel(sel_c),
    .y(y_c), .y_valid(v_c), .scan_idx(idx_c), .wrap(w_c)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] e8(input logic [7:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] e16(input logic [15:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output set of instance a.
  task automatic chk_a(input string tag, input logic [7:0] y, input logic v,
                       input logic [2:0] idx, input logic w);
    chk({tag, ".y"}, 32'(y_a), 32'(e8(y)));
    chk({tag, ".valid"}, 32'(v_a), 32'(v));
    chk({tag, ".idx"}, 32'(idx_a), 32'(idx));
    chk({tag, ".wrap"}, 32'(w_a), 32'(w));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] y, input logic v,
                       input logic [2:0] idx, input logic w);
    chk({tag, ".y"}, 32'(y_b), 32'(e8(y)));
    chk({tag, ".valid"}, 32'(v_b), 32'(v));
    chk({tag, ".idx"}, 32'(idx_b), 32'(idx));
    chk({tag, ".wrap"}, 32'(w_b), 32'(w));
  endtask

  initial begin
    rst_n = 1'b0;
    {en_a, load_a, mode_a, sel_a} = '0;
    {en_b, load_b, mode_b, sel_b} = '0;
    {en_c, load_c, mode_c, sel_c} = '0;
    repeat (3) tick();

    // Reset state
    chk_a("rst_a", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("rst_c.y", 32'(y_c), 32'(e16(16'h0000)));
    chk("rst_c.valid", 32'(v_c), 32'd0);
    rst_n = 1'b1;

    // Enabled but no load: stays idle
    en_a = 1'b1;
    tick();
    chk_a("idle", 8'h00, 1'b0, 3'd0, 1'b0);

    // Direct decode sel=5
    load_a = 1'b1; mode_a = 1'b0; sel_a = 3'd5;
    tick();
    load_a = 1'b0;
    chk_a("direct5", 8'h20, 1'b1, 3'd5, 1'b0);
    sel_a = 3'd2;
    tick();
    chk_a("direct_sel_ignored", 8'h20, 1'b1, 3'd5, 1'b0);
    tick();
    chk_a("direct_hold", 8'h20, 1'b1, 3'd5, 1'b0);

    // Scan from 6: 4 cycles at 6, 4 at 7, then wrap to 0
    load_a = 1'b1; mode_a = 1'b1; sel_a = 3'd6;
    tick();
    load_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_a("scan6", 8'h40, 1'b1, 3'd6, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk_a("scan7", 8'h80, 1'b1, 3'd7, 1'b0);
      tick();
    end
    chk_a("scan_wrap", 8'h01, 1'b1, 3'd0, 1'b1);
    tick();
    chk_a("scan_after_wrap", 8'h01, 1'b1, 3'd0, 1'b0);

    // Run to idx 3 with two hold cycles elapsed
    repeat (13) tick();
    chk_a("scan_idx3", 8'h08, 1'b1, 3'd3, 1'b0);

    // Freeze for 10 cycles
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a("freeze", 8'h08, 1'b1, 3'd3, 1'b0);
    end
    en_a = 1'b1;
    tick();
    chk_a("resume_hold", 8'h08, 1'b1, 3'd3, 1'b0);
    tick();
    chk_a("resume_step", 8'h10, 1'b1, 3'd4, 1'b0);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_a("post_rst_idle", 8'h00, 1'b0, 3'd0, 1'b0);

    // SCAN_HOLD=1: step every cycle, wrap, then load/step collision
    en_b = 1'b1; load_b = 1'b1; mode_b = 1'b1; sel_b = 3'd6;
    tick();
    load_b = 1'b0;
    chk_b("h1_load6", 8'h40, 1'b1, 3'd6, 1'b0);
    tick();
    chk_b("h1_step7", 8'h80, 1'b1, 3'd7, 1'b0);
    tick();
    chk_b("h1_wrap", 8'h01, 1'b1, 3'd0, 1'b1);
    tick();
    chk_b("h1_step1", 8'h02, 1'b1, 3'd1, 1'b0);
    repeat (6) tick();
    chk_b("h1_at7", 8'h80, 1'b1, 3'd7, 1'b0);
    load_b = 1'b1; mode_b = 1'b0; sel_b = 3'd1;
    tick();
    load_b = 1'b0;
    chk_b("collision", 8'h02, 1'b1, 3'd1, 1'b0);
    tick();
    chk_b("collision_direct", 8'h02, 1'b1, 3'd1, 1'b0);

    // SEL_W=4 direct decode sel=9
    en_c = 1'b1; load_c = 1'b1; mode_c = 1'b0; sel_c = 4'd9;
    tick();
    load_c = 1'b0;
    chk("w4.y", 32'(y_c), 32'(e16(16'h0200)));
    chk("w4.valid", 32'(v_c), 32'd1);
    chk("w4.idx", 32'(idx_c), 32'd9);
    chk("w4.wrap", 32'(w_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
